// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin sharing of one GCD engine among NREQ clients,
// with a watchdog that aborts transactions the engine never finishes.
module gcd_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*WIDTH-1:0] a_i,
   input  logic [NREQ*WIDTH-1:0] b_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic [NREQ-1:0]       done_o,
   output logic                  err_o,
   output logic [WIDTH-1:0]      result_o,
   output logic                  busy_o,
   output logic                  slv_req_o,
   output logic [WIDTH-1:0]      slv_a_o,
   output logic [WIDTH-1:0]      slv_b_o,
   input  logic                  slv_busy_i,
   input  logic                  slv_valid_i,
   input  logic [WIDTH-1:0]      slv_result_i
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t          r_state;
   logic [IW-1:0]   r_ptr, r_id, w_win;
   logic [CW-1:0]   r_cnt;
   logic            r_err;
   logic [WIDTH-1:0] r_a, r_b, r_result, w_a, w_b;
   // Scan from the highest offset down so the client nearest ptr wins.
   always_comb begin
      w_win = r_ptr;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req_i[IW'((int'(r_ptr) + i) % NREQ)]) w_win = IW'((int'(r_ptr) + i) % NREQ);
   end
   assign w_a = WIDTH'(a_i >> (int'(w_win) * WIDTH));
   assign w_b = WIDTH'(b_i >> (int'(w_win) * WIDTH));
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_id     <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE:
               if (|req_i && !slv_busy_i) begin
                  r_id    <= w_win;
                  r_a     <= w_a;
                  r_b     <= w_b;
                  r_state <= ISSUE;
               end
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT:
               if (slv_valid_i) begin
                  r_result <= slv_result_i;
                  r_err    <= 1'b0;
                  r_state  <= DONE;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_result <= '0;
                  r_err    <= 1'b1;
                  r_state  <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            DONE: begin
               r_ptr   <= (r_id == IW'(NREQ - 1)) ? '0 : r_id + 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end
   assign busy_o    = r_state != IDLE;
   assign gnt_o     = busy_o ? NREQ'(1) << r_id : '0;
   assign done_o    = (r_state == DONE) ? NREQ'(1) << r_id : '0;
   assign err_o     = (r_state == DONE) && r_err;
   assign slv_req_o = r_state == ISSUE;
   assign result_o  = r_result;
   assign slv_a_o   = r_a;
   assign slv_b_o   = r_b;
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed test of gcd_arbiter with a behavioural GCD engine
// whose latency, busy level and silence are controlled by the stimulus.
module tb_gcd_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] a_in, b_in;
   logic [3:0]  gnt_o, done_o, result_o, slv_a_o, slv_b_o, slv_result;
   logic        err_o, busy_o, slv_req_o, slv_busy, slv_valid;
   logic        force_busy, mute;
   int          lat, eng_cnt, cyc, g, checks, errors;
   logic [3:0]  ea, eb, d;

   gcd_arbiter #(.NREQ(4), .WIDTH(4), .TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .a_i(a_in), .b_i(b_in),
      .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
      .busy_o(busy_o), .slv_req_o(slv_req_o), .slv_a_o(slv_a_o), .slv_b_o(slv_b_o),
      .slv_busy_i(slv_busy), .slv_valid_i(slv_valid), .slv_result_i(slv_result)
   );

   always #5 clk = ~clk;

   function automatic int gcd(int x, int y);
      int t;
      while (y != 0) begin
         t = y;
         y = x % y;
         x = t;
      end
      return x;
   endfunction

   // Engine: captures operands on the start pulse, answers after lat cycles.
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      slv_valid <= 1'b0;
      if (rst) eng_cnt <= 0;
      else if (slv_req_o) begin
         ea      <= slv_a_o;
         eb      <= slv_b_o;
         eng_cnt <= lat;
      end else if (eng_cnt == 1) begin
         slv_valid  <= !mute;
         slv_result <= 4'(gcd(int'(ea), int'(eb)));
         eng_cnt    <= 0;
      end else if (eng_cnt > 1) eng_cnt <= eng_cnt - 1;
   end
   assign slv_busy = force_busy || (eng_cnt != 0);

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic setop(input int k, input int a, input int b);
      a_in[k*4 +: 4] = 4'(a);
      b_in[k*4 +: 4] = 4'(b);
   endtask

   task automatic wait_done(input string tag);
      d = '0;
      for (int n = 0; n < 40 && d == 0; n++) begin
         @(negedge clk);
         d = done_o;
      end
      if (d == 0) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic serve(input string tag, input int k, input int er);
      wait_done(tag);
      check({tag, "_done"}, int'(d), 1 << k);
      check({tag, "_res"}, int'(result_o), er);
      check({tag, "_err"}, int'(err_o), 0);
      req[k] = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, int'(gnt_o), 0);
      check({tag, "_done"}, int'(done_o), 0);
      check({tag, "_err"}, int'(err_o), 0);
      check({tag, "_res"}, int'(result_o), 0);
      check({tag, "_busy"}, int'(busy_o), 0);
      check({tag, "_sreq"}, int'(slv_req_o), 0);
      check({tag, "_sa"}, int'(slv_a_o), 0);
      check({tag, "_sb"}, int'(slv_b_o), 0);
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      rst = 1'b1; req = '0; a_in = '0; b_in = '0;
      force_busy = 1'b0; mute = 1'b0; lat = 5;
      repeat (3) @(negedge clk);
      check_zero("rst");
      rst = 1'b0;
      @(negedge clk);
      // single client: valid lands 7 cycles after the grant, done one later
      setop(0, 12, 8); req = 4'b0001; g = cyc;
      @(negedge clk);
      check("s_sreq1", int'(slv_req_o), 1);
      check("s_gnt", int'(gnt_o), 1);
      check("s_sa", int'(slv_a_o), 12);
      check("s_sb", int'(slv_b_o), 8);
      @(negedge clk);
      check("s_sreq2", int'(slv_req_o), 0);
      serve("s", 0, 4);
      check("s_lat", cyc - g, 8);
      @(negedge clk);
      check("s_idle", int'(busy_o), 0);
      // reset restores ptr to 0 so all four are served in index order
      rst = 1'b1;
      @(negedge clk);
      check_zero("rst2");
      rst = 1'b0; lat = 3;
      setop(0, 9, 6); setop(1, 10, 4); setop(2, 7, 3); setop(3, 15, 5);
      req = 4'b1111;
      serve("all0", 0, 3);
      serve("all1", 1, 2);
      serve("all2", 2, 1);
      serve("all3", 3, 5);
      // client 2 alone, then 1 and 3 together: 3 comes first
      @(negedge clk);
      setop(2, 8, 12); req = 4'b0100;
      serve("rot2", 2, 4);
      @(negedge clk);
      setop(1, 6, 9); setop(3, 10, 15); req = 4'b1010;
      serve("rot3", 3, 5);
      serve("rot1", 1, 3);
      // engine busy holds the arbiter in IDLE
      @(negedge clk);
      force_busy = 1'b1; setop(1, 4, 6); req = 4'b0010;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("bsy_sreq", int'(slv_req_o), 0);
         check("bsy_busy", int'(busy_o), 0);
      end
      force_busy = 1'b0;
      @(negedge clk);
      check("bsy_go", int'(slv_req_o), 1);
      check("bsy_gnt", int'(gnt_o), 2);
      serve("bsy", 1, 2);
      // silent engine: watchdog fires TIMEOUT+2 cycles after the grant
      @(negedge clk);
      mute = 1'b1; setop(0, 3, 5); req = 4'b0001; g = cyc;
      wait_done("to");
      check("to_lat", cyc - g, 10);
      check("to_done", int'(d), 1);
      check("to_err", int'(err_o), 1);
      check("to_res", int'(result_o), 0);
      req = '0; mute = 1'b0;
      @(negedge clk);
      check("to_idle", int'(busy_o), 0);
      // reset in WAIT abandons the transaction
      lat = 20; setop(2, 6, 4); req = 4'b0100;
      repeat (3) @(negedge clk);
      check("rw_gnt", int'(gnt_o), 4);
      rst = 1'b1; req = '0;
      @(negedge clk);
      check_zero("rw");
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("rw_nodone", int'(done_o), 0);
      end
      // ptr is 0 again: client 0 beats client 3; operand change is ignored
      lat = 3; setop(0, 12, 9); setop(3, 15, 10); req = 4'b1001;
      @(negedge clk);
      @(negedge clk);
      check("op_gnt", int'(gnt_o), 1);
      setop(0, 5, 9);
      @(negedge clk);
      check("op_sa", int'(slv_a_o), 12);
      serve("op0", 0, 3);
      serve("op3", 3, 5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
